// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared constants for the ALU command issuer: FSM states,
//               unit-class codes carried in ALU_FUN[3:2], default sizes.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  localparam int C_DEF_WIDTH   = 8;
  localparam int C_DEF_DEPTH   = 4;
  localparam int C_DEF_TIMEOUT = 15;

  localparam logic [1:0] C_UNIT_ARITH = 2'b00;
  localparam logic [1:0] C_UNIT_LOGIC = 2'b01;
  localparam logic [1:0] C_UNIT_CMP   = 2'b10;
  localparam logic [1:0] C_UNIT_SHIFT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic logic [1:0] unit_class(input logic [3:0] fun);
    return fun[3:2];
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_cmd_issuer_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_cmd_issuer_if
// Description : Command, ALU-side and result-side signals of the issuer.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_cmd_issuer_if
  import alu_pkg::*;
#(
  parameter int WIDTH = C_DEF_WIDTH
);

  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [3:0]           cmd_fun;
  logic [WIDTH-1:0]     cmd_a;
  logic [WIDTH-1:0]     cmd_b;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic [3:0]           alu_fun;
  logic                 alu_en;
  logic [2*WIDTH-1:0]   alu_out;
  logic                 out_valid;
  logic                 res_valid;
  logic                 res_ready;
  logic [2*WIDTH-1:0]   res_data;
  logic [3:0]           res_fun;
  logic                 res_timeout;

  modport master (
    input  cmd_valid, cmd_fun, cmd_a, cmd_b, alu_out, out_valid, res_ready,
    output cmd_ready, a, b, alu_fun, alu_en, res_valid, res_data, res_fun,
           res_timeout
  );

  modport slave (
    output cmd_valid, cmd_fun, cmd_a, cmd_b, alu_out, out_valid, res_ready,
    input  cmd_ready, a, b, alu_fun, alu_en, res_valid, res_data, res_fun,
           res_timeout
  );

endinterface
`default_nettype wire

// File: rtl/alu_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module      : alu_cmd_fifo
// Description : Power-of-two command FIFO with first-word-fall-through head.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_cmd_fifo #(
  parameter int DATA_W = 20,
  parameter int DEPTH  = 4
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              push,
  input  wire logic              pop,
  input  wire logic [DATA_W-1:0] din,
  output logic                   full,
  output logic                   empty,
  output logic [DATA_W-1:0]      head
);

  localparam int                 c_ptr_w = $clog2(DEPTH);
  localparam logic [c_ptr_w:0]   c_full  = (c_ptr_w + 1)'(DEPTH);

  logic [DATA_W-1:0]  r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_ptr_w:0]   r_count;
  logic               w_do_push;
  logic               w_do_pop;

  assign full      = (r_count == c_full);
  assign empty     = (r_count == '0);
  assign head      = r_mem[r_rd_ptr];
  assign w_do_push = push & ~full;
  assign w_do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally; the extra count bit separates full from empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      end
      if (w_do_push && !w_do_pop) begin
        r_count <= r_count + (c_ptr_w + 1)'(1);
      end else if (!w_do_push && w_do_pop) begin
        r_count <= r_count - (c_ptr_w + 1)'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_cmd_issuer.sv
`default_nettype none
// ============================================================================
// Module      : alu_cmd_issuer
// Description : Queues ALU commands, issues them one at a time, waits for the
//               result with a timeout and presents it on a valid/ready port.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_cmd_issuer
  import alu_pkg::*;
#(
  parameter int WIDTH   = C_DEF_WIDTH,
  parameter int DEPTH   = C_DEF_DEPTH,
  parameter int TIMEOUT = C_DEF_TIMEOUT
) (
  input wire logic         clk,
  input wire logic         rst,
  alu_cmd_issuer_if.master bus
);

  localparam int         c_entry_w = 4 + 2 * WIDTH;
  localparam logic [7:0] c_to_last = 8'(TIMEOUT - 1);

  state_t               r_state;
  state_t               w_state_next;
  logic [7:0]           r_cnt;
  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_b;
  logic [3:0]           r_alu_fun;
  logic                 r_alu_en;
  logic [2*WIDTH-1:0]   r_res_data;
  logic [3:0]           r_res_fun;
  logic                 r_res_timeout;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_start;
  logic [c_entry_w-1:0] w_head;

  assign w_push  = bus.cmd_valid & ~w_full;
  assign w_pop   = (r_state == ST_ISSUE);
  assign w_start = (r_state == ST_IDLE) & ~w_empty;

  alu_cmd_fifo #(
    .DATA_W (c_entry_w),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .din   ({bus.cmd_fun, bus.cmd_a, bus.cmd_b}),
    .full  (w_full),
    .empty (w_empty),
    .head  (w_head)
  );

  assign bus.cmd_ready   = ~w_full;
  assign bus.res_valid   = (r_state == ST_DONE);
  assign bus.a           = r_a;
  assign bus.b           = r_b;
  assign bus.alu_fun     = r_alu_fun;
  assign bus.alu_en      = r_alu_en;
  assign bus.res_data    = r_res_data;
  assign bus.res_fun     = r_res_fun;
  assign bus.res_timeout = r_res_timeout;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_start) w_state_next = ST_ISSUE;
      ST_ISSUE: w_state_next = ST_WAIT;
      ST_WAIT:  if (bus.out_valid || (r_cnt == c_to_last)) w_state_next = ST_DONE;
      ST_DONE:  if (bus.res_ready) w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // Operands are loaded on the edge entering ISSUE so they and ALU_EN are
  // valid for the whole ISSUE cycle; the head is popped on the edge leaving it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_a           <= '0;
      r_b           <= '0;
      r_alu_fun     <= '0;
      r_alu_en      <= 1'b0;
      r_res_data    <= '0;
      r_res_fun     <= '0;
      r_res_timeout <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_alu_en <= w_start;
      r_cnt    <= (r_state == ST_WAIT) ? r_cnt + 8'd1 : 8'd0;
      if (w_start) begin
        r_alu_fun <= w_head[c_entry_w-1 -: 4];
        r_a       <= w_head[2*WIDTH-1 -: WIDTH];
        r_b       <= w_head[WIDTH-1:0];
      end
      // A result arriving on the expiry cycle wins over the abort.
      if (r_state == ST_WAIT) begin
        if (bus.out_valid) begin
          r_res_data    <= bus.alu_out;
          r_res_fun     <= r_alu_fun;
          r_res_timeout <= 1'b0;
        end else if (r_cnt == c_to_last) begin
          r_res_data    <= '0;
          r_res_fun     <= r_alu_fun;
          r_res_timeout <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_issuer.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_cmd_issuer
// Description : Self-checking bench; an ALU responder and a queue-based model
//               predict every result from the commands offered.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_cmd_issuer;
  import alu_pkg::*;

  localparam int WIDTH   = 8;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 15;
  localparam int NEVER   = 1000;

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  fun;
    logic        to;
  } res_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        resp_ov;
  logic        stray_ov;
  logic [15:0] resp_data;
  logic [15:0] stray_data;
  res_t        exp_q[$];
  int          delay_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          issue_cnt = 0;

  always #5 clk = ~clk;

  alu_cmd_issuer_if #(.WIDTH(WIDTH)) bus ();

  alu_cmd_issuer #(
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  assign bus.out_valid = resp_ov | stray_ov;
  assign bus.alu_out   = resp_ov ? resp_data : stray_data;

  function automatic logic [15:0] ref_alu(input logic [3:0] f, input logic [7:0] x8, input logic [7:0] y8);
    int x, y, r;
    x = int'(x8);
    y = int'(y8);
    case (f)
      4'd0:    r = x + y;
      4'd1:    r = x - y;
      4'd2:    r = x * y;
      4'd3:    r = x;
      4'd4:    r = x & y;
      4'd5:    r = x | y;
      4'd6:    r = x ^ y;
      4'd7:    r = 255 - x;
      4'd8:    r = (x == y) ? 1 : 0;
      4'd9:    r = (x < y) ? 1 : 0;
      4'd10:   r = (x > y) ? 1 : 0;
      4'd11:   r = (x != y) ? 1 : 0;
      4'd12:   r = x << (y % 8);
      4'd13:   r = x >> (y % 8);
      4'd14:   r = x * 256;
      default: r = y;
    endcase
    return r[15:0];
  endfunction

  // A result arriving within TIMEOUT WAIT cycles is captured, else aborted.
  function automatic res_t expect_of(input logic [3:0] f, input logic [7:0] x, input logic [7:0] y, input int d);
    res_t e;
    if (d < TIMEOUT) e = '{data: ref_alu(f, x, y), fun: f, to: 1'b0};
    else             e = '{data: 16'h0, fun: f, to: 1'b1};
    return e;
  endfunction

  // ALU responder: answers d+1 cycles into WAIT, or never when d >= TIMEOUT.
  initial begin
    int d;
    logic [3:0] f;
    logic [7:0] x, y;
    resp_ov   = 1'b0;
    resp_data = 16'h0;
    forever begin
      @(posedge clk); #1;
      if (bus.alu_en === 1'b1) begin
        f = bus.alu_fun;
        x = bus.a;
        y = bus.b;
        issue_cnt++;
        d = (delay_q.size() > 0) ? delay_q.pop_front() : NEVER;
        if (d < TIMEOUT) begin
          @(posedge clk); #1;
          repeat (d) begin @(posedge clk); #1; end
          resp_data = ref_alu(f, x, y);
          resp_ov   = 1'b1;
          @(posedge clk); #1;
          resp_ov   = 1'b0;
        end
      end
    end
  end

  task automatic push_cmd(input logic [3:0] f, input logic [7:0] x, input logic [7:0] y,
                          input int d, output bit acc);
    bus.cmd_valid = 1'b1;
    bus.cmd_fun   = f;
    bus.cmd_a     = x;
    bus.cmd_b     = y;
    acc = (bus.cmd_ready === 1'b1);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    if (acc) begin
      exp_q.push_back(expect_of(f, x, y, d));
      delay_q.push_back(d);
    end
  endtask

  task automatic wait_res_valid(input int budget, output bit ok);
    int k;
    k = 0;
    while (bus.res_valid !== 1'b1 && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    ok = (bus.res_valid === 1'b1);
  endtask

  task automatic drain_results(input string tag, input int n, input int budget, input bit rand_ready);
    int   got, cyc;
    bit   rr;
    res_t act;
    got = 0;
    cyc = 0;
    while (got < n && cyc < budget) begin
      rr = rand_ready ? bit'($urandom_range(0, 1)) : 1'b1;
      bus.res_ready = rr;
      if (bus.res_valid === 1'b1) begin
        act = '{data: bus.res_data, fun: bus.res_fun, to: bus.res_timeout};
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL %s unexpected_result got=%h exp=none", tag, act);
        end else if (act !== exp_q[0]) begin
          $display("FAIL %s result got=%h exp=%h", tag, act, exp_q[0]);
        end else begin
          n_pass++;
        end
        if (rr) begin
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          got++;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.res_ready = 1'b0;
    n_checks++;
    if (got != n) $display("FAIL %s drain_count got=%0d exp=%0d", tag, got, n);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd_fun   = 4'h1;
    bus.cmd_a     = 8'h11;
    bus.cmd_b     = 8'h22;
    repeat (3) begin @(posedge clk); #1; end
    n_checks++;
    if (bus.cmd_ready !== 1'b1) $display("FAIL rst_cmd_ready got=%b exp=1", bus.cmd_ready);
    else n_pass++;
    n_checks++;
    if ({bus.alu_en, bus.res_valid, bus.res_timeout} !== 3'b000)
      $display("FAIL rst_flags got=%b exp=000", {bus.alu_en, bus.res_valid, bus.res_timeout});
    else n_pass++;
    n_checks++;
    if ({bus.alu_fun, bus.a, bus.b} !== 20'h0) $display("FAIL rst_operands got=%h exp=0", {bus.alu_fun, bus.a, bus.b});
    else n_pass++;
    n_checks++;
    if ({bus.res_fun, bus.res_data} !== 20'h0) $display("FAIL rst_result got=%h exp=0", {bus.res_fun, bus.res_data});
    else n_pass++;
    rst           = 1'b0;
    bus.cmd_valid = 1'b0;
    repeat (6) begin @(posedge clk); #1; end
    n_checks++;
    if (issue_cnt != 0) $display("FAIL rst_no_push got=%0d exp=0", issue_cnt);
    else n_pass++;
  endtask

  task automatic test_single();
    bit acc;
    int base;
    base = issue_cnt;
    push_cmd(4'b0000, 8'h05, 8'h03, 0, acc);
    n_checks++;
    if (bus.alu_en !== 1'b0) $display("FAIL single_en_early got=%b exp=0", bus.alu_en); else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if ({bus.alu_en, bus.alu_fun, bus.a, bus.b} !== {1'b1, 4'h0, 8'h05, 8'h03})
      $display("FAIL single_issue got=%h exp=%h", {bus.alu_en, bus.alu_fun, bus.a, bus.b}, {1'b1, 4'h0, 8'h05, 8'h03});
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if ({bus.alu_en, bus.res_valid} !== 2'b00) $display("FAIL single_wait got=%b exp=00", {bus.alu_en, bus.res_valid});
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if ({bus.res_valid, bus.res_data, bus.res_fun, bus.res_timeout} !== {1'b1, 16'h0008, 4'h0, 1'b0})
      $display("FAIL single_result got=%h exp=%h", {bus.res_valid, bus.res_data, bus.res_fun, bus.res_timeout},
               {1'b1, 16'h0008, 4'h0, 1'b0});
    else n_pass++;
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    exp_q.delete();
    repeat (3) begin @(posedge clk); #1; end
    n_checks++;
    if ({bus.res_valid, 32'(issue_cnt - base)} !== {1'b0, 32'd1})
      $display("FAIL single_one_pulse got=%b/%0d exp=0/1", bus.res_valid, issue_cnt - base);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    bit acc, ok;
    push_cmd(4'h2, 8'h07, 8'h09, 0, acc);
    wait_res_valid(10, ok);
    n_checks++;
    if (!ok) $display("FAIL bp_first_result got=0 exp=1"); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      push_cmd(4'($urandom), 8'($urandom), 8'($urandom), 0, acc);
      n_checks++;
      if (acc !== (i < DEPTH)) $display("FAIL bp_ready_%0d got=%b exp=%b", i, acc, (i < DEPTH));
      else n_pass++;
    end
    repeat (4) begin @(posedge clk); #1; end
    n_checks++;
    if ({bus.res_valid, bus.cmd_ready, bus.res_data, bus.res_fun, bus.res_timeout} !== {2'b10, exp_q[0]})
      $display("FAIL bp_hold got=%h exp=%h", {bus.res_valid, bus.cmd_ready, bus.res_data, bus.res_fun, bus.res_timeout},
               {2'b10, exp_q[0]});
    else n_pass++;
    drain_results("bp_drain", DEPTH + 1, 200, 1'b0);
  endtask

  task automatic test_timeout();
    bit acc;
    push_cmd(4'h5, 8'h3c, 8'h0f, NEVER, acc);
    repeat (16) begin @(posedge clk); #1; end
    n_checks++;
    if (bus.res_valid !== 1'b0) $display("FAIL to_early got=%b exp=0", bus.res_valid); else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if ({bus.res_valid, bus.res_data, bus.res_fun, bus.res_timeout} !== {1'b1, 16'h0, 4'h5, 1'b1})
      $display("FAIL to_result got=%h exp=%h", {bus.res_valid, bus.res_data, bus.res_fun, bus.res_timeout},
               {1'b1, 16'h0, 4'h5, 1'b1});
    else n_pass++;
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    exp_q.delete();
    push_cmd(4'h6, 8'ha5, 8'h5a, 2, acc);
    drain_results("to_next", 1, 40, 1'b0);
  endtask

  task automatic test_simultaneous();
    bit acc;
    int base;
    push_cmd(4'hc, 8'h03, 8'h02, TIMEOUT - 1, acc);
    drain_results("sim_expiry", 1, 40, 1'b0);
    base       = issue_cnt;
    stray_data = 16'hbeef;
    stray_ov   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (bus.res_valid !== 1'b0) $display("FAIL stray_valid_%0d got=%b exp=0", i, bus.res_valid);
      else n_pass++;
    end
    stray_ov = 1'b0;
    n_checks++;
    if (issue_cnt != base) $display("FAIL stray_issue got=%0d exp=%0d", issue_cnt, base); else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit acc, seen;
    int base;
    for (int i = 0; i < 4; i++) begin
      push_cmd(4'(i + 4), 8'(i), 8'(i * 3), NEVER, acc);
      n_checks++;
      if (!acc) $display("FAIL rmid_push_%0d got=0 exp=1", i); else n_pass++;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    delay_q.delete();
    n_checks++;
    if ({bus.cmd_ready, bus.alu_en, bus.res_valid, bus.res_timeout, bus.a, bus.b, bus.alu_fun, bus.res_data, bus.res_fun}
        !== {1'b1, 43'h0})
      $display("FAIL rmid_outputs got=%h exp=%h",
               {bus.cmd_ready, bus.alu_en, bus.res_valid, bus.res_timeout, bus.a, bus.b, bus.alu_fun, bus.res_data, bus.res_fun},
               {1'b1, 43'h0});
    else n_pass++;
    base = issue_cnt;
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus.res_valid === 1'b1 || bus.alu_en === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (seen || issue_cnt != base) $display("FAIL rmid_quiet got=%b/%0d exp=0/%0d", seen, issue_cnt, base);
    else n_pass++;
    push_cmd(4'h9, 8'h10, 8'h20, 0, acc);
    drain_results("rmid_after", 1, 40, 1'b0);
  endtask

  task automatic test_wrap();
    logic [1:0] cls [4];
    cls = '{C_UNIT_ARITH, C_UNIT_LOGIC, C_UNIT_CMP, C_UNIT_SHIFT};
    fork
      begin
        bit acc;
        int tries;
        for (int i = 0; i < 10; i++) begin
          tries = 0;
          acc   = 1'b0;
          while (!acc && tries < 40) begin
            push_cmd({cls[i % 4], 2'($urandom)}, 8'($urandom), 8'($urandom), int'($urandom_range(0, 3)), acc);
            tries++;
          end
        end
      end
      drain_results("wrap", 10, 400, 1'b0);
    join
  endtask

  task automatic test_random();
    fork
      begin
        bit acc;
        int tries;
        for (int i = 0; i < 40; i++) begin
          tries = 0;
          acc   = 1'b0;
          while (!acc && tries < 200) begin
            push_cmd(4'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(0, TIMEOUT + 2)), acc);
            tries++;
          end
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
      end
      drain_results("random", 40, 4000, 1'b1);
    join
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst           = 1'b1;
    stray_ov      = 1'b0;
    stray_data    = 16'h0;
    bus.cmd_valid = 1'b0;
    bus.cmd_fun   = 4'h0;
    bus.cmd_a     = 8'h0;
    bus.cmd_b     = 8'h0;
    bus.res_ready = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_timeout();
    test_simultaneous();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
